// File: rtl/dct_2d_seq.sv
// dct_2d_seq: runs one shared 8-point 1D DCT core over the rows, then the columns, of an 8x8 block.
// Latency: 17+2*DCT_LAT cycles from block acceptance to res_valid; one block in flight at a time.
// Backpressure: blk_ready is low from acceptance until after the result handshake; res_ready low holds the result.
// Optional: define DCT_SEQ_STATS_EN to add a 16-bit completed-block counter output (blk_count).
module dct_2d_seq #(
  parameter int DCT_LAT = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic [63:0]  core_in,
  input  logic [63:0]  core_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [511:0] res_data,
  output logic         busy
`ifdef DCT_SEQ_STATS_EN
  ,
  output logic [15:0]  blk_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, ROW, ROW_DRAIN, COL, COL_DRAIN, DONE
  } state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [511:0]  pix_buf;
  logic [63:0]   row_buf [8];
  logic [63:0]   col_buf [8];
  logic [63:0]   col_vec;

  // Tag pipeline: follows each issued vector through the core so its result lands in the right slot.
  logic [DCT_LAT-1:0]       tag_vld;
  logic [DCT_LAT-1:0]       tag_col;
  logic [DCT_LAT-1:0][2:0]  tag_idx;

  logic       issue;
  logic       cap_vld;
  logic       cap_col;
  logic [2:0] cap_idx;

  assign issue   = (state == ROW) || (state == COL);
  assign cap_vld = tag_vld[DCT_LAT-1];
  assign cap_col = tag_col[DCT_LAT-1];
  assign cap_idx = tag_idx[DCT_LAT-1];

  // Column c is byte c of every row result, stacked with row r as element r.
  for (genvar r = 0; r < 8; r++) begin : g_colvec
    assign col_vec[r*8 +: 8] = row_buf[r][{cnt, 3'b000} +: 8];
  end

  // Coefficient (r,c) is element r of column result c; zero whenever no result is offered.
  for (genvar r = 0; r < 8; r++) begin : g_res_r
    for (genvar c = 0; c < 8; c++) begin : g_res_c
      assign res_data[(r*8+c)*8 +: 8] = res_valid ? col_buf[c][r*8 +: 8] : 8'h00;
    end
  end

  // Drive the core only in issue cycles; idle cycles carry zero.
  always_comb begin
    core_in = '0;
    case (state)
      ROW:     core_in = pix_buf[{cnt, 6'b000000} +: 64];
      COL:     core_in = col_vec;
      default: core_in = '0;
    endcase
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      pix_buf   <= '0;
      blk_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid && blk_ready) begin
            pix_buf   <= blk_data;
            cnt       <= 3'd0;
            blk_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ROW;
          end
        end
        ROW: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ROW_DRAIN;
        end
        ROW_DRAIN: begin
          if (cap_vld && !cap_col && cap_idx == 3'd7) state <= COL;
        end
        COL: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= COL_DRAIN;
        end
        COL_DRAIN: begin
          if (cap_vld && cap_col && cap_idx == 3'd7) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          blk_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Shift the issue tags alongside the core pipeline; reset drops anything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld <= '0;
      tag_col <= '0;
      tag_idx <= '0;
    end else begin
      for (int i = DCT_LAT-1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_col[i] <= tag_col[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      tag_vld[0] <= issue;
      tag_col[0] <= (state == COL);
      tag_idx[0] <= cnt;
    end
  end

  // Capture returning core results into the row or column buffer named by the tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        row_buf[i] <= '0;
        col_buf[i] <= '0;
      end
    end else if (cap_vld) begin
      if (cap_col) col_buf[cap_idx] <= core_out;
      else         row_buf[cap_idx] <= core_out;
    end
  end

`ifdef DCT_SEQ_STATS_EN
  // Count completed result handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                   blk_count <= 16'd0;
    else if (res_valid && res_ready) blk_count <= blk_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dct_2d_seq.sv
// Bench for dct_2d_seq: two instances (core latency 1 and 3) with byte-wise core models.
// Random blocks are compared against a matrix-level row-then-column reference.
// Covers latency, transpose order, backpressure, back-to-back acceptance and mid-block reset.
module tb_dct_2d_seq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sel;
  logic         blk_valid;
  logic         res_ready;
  logic [511:0] blk_data;
  logic         core_add;

  logic         blk_ready1, res_valid1, busy1;
  logic [63:0]  core_in1, core_out1;
  logic [511:0] res_data1;
  logic         blk_ready3, res_valid3, busy3;
  logic [63:0]  core_in3, core_out3;
  logic [511:0] res_data3;
`ifdef DCT_SEQ_STATS_EN
  logic [15:0]  blk_count1, blk_count3;
`endif

  logic         rdy_v, rv_v, busy_v;
  logic [63:0]  ci_v;
  logic [511:0] rd_v;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;

  dct_2d_seq #(.DCT_LAT(1)) u_dut1 (
    .clock(clk), .reset_n(reset_n),
    .blk_valid(blk_valid & ~sel), .blk_ready(blk_ready1), .blk_data(blk_data),
    .core_in(core_in1), .core_out(core_out1),
    .res_valid(res_valid1), .res_ready(res_ready & ~sel), .res_data(res_data1),
    .busy(busy1)
`ifdef DCT_SEQ_STATS_EN
    , .blk_count(blk_count1)
`endif
  );

  dct_2d_seq #(.DCT_LAT(3)) u_dut3 (
    .clock(clk), .reset_n(reset_n),
    .blk_valid(blk_valid & sel), .blk_ready(blk_ready3), .blk_data(blk_data),
    .core_in(core_in3), .core_out(core_out3),
    .res_valid(res_valid3), .res_ready(res_ready & sel), .res_data(res_data3),
    .busy(busy3)
`ifdef DCT_SEQ_STATS_EN
    , .blk_count(blk_count3)
`endif
  );

  assign rdy_v  = sel ? blk_ready3 : blk_ready1;
  assign rv_v   = sel ? res_valid3 : res_valid1;
  assign busy_v = sel ? busy3      : busy1;
  assign ci_v   = sel ? core_in3   : core_in1;
  assign rd_v   = sel ? res_data3  : res_data1;

  function automatic logic [63:0] core_fn(input logic [63:0] v, input logic add);
    logic [63:0] o;
    for (int k = 0; k < 8; k++) o[k*8 +: 8] = v[k*8 +: 8] + {7'd0, add};
    return o;
  endfunction

  // Core models: plain delay lines applying the byte function; never reset.
  logic [63:0] p1;
  logic [63:0] p3 [3];
  always @(posedge clk) begin
    p1    <= core_fn(core_in1, core_add);
    p3[0] <= core_fn(core_in3, core_add);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign core_out1 = p1;
  assign core_out3 = p3[2];

  // Acceptance monitor and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && blk_valid && rdy_v) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
  end

  // Reference 2D pass: row transform, then column transform, then read out as (r,c).
  function automatic logic [511:0] ref_blk(input logic [511:0] pix, input logic add);
    logic [7:0] m [8][8];
    logic [7:0] t [8][8];
    logic [511:0] o;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = pix[(r*8+c)*8 +: 8] + {7'd0, add};
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        t[c][r] = m[r][c] + {7'd0, add};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        o[(r*8+c)*8 +: 8] = t[c][r];
    return o;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block through the selected instance: accept, wait for result, optional hold, handshake.
  task automatic run_blk(input logic [511:0] blk, input int hold, input bit keep,
                         output logic [511:0] got);
    int n;
    int a0;
    int exp_lat;
    bit ok;
    logic [511:0] exp;
    exp     = ref_blk(blk, core_add);
    exp_lat = sel ? 23 : 19;
    a0      = acc_cnt;
    blk_data  = blk;
    blk_valid = 1'b1;
    n = 0;
    while (!rdy_v && n < 50) begin tick(); n++; end
    tick();
    if (!keep) blk_valid = 1'b0;
    blk_data = rand_blk();
    n = 1;
    while (!rv_v && n < 60) begin tick(); n++; end
    got = rd_v;
    check("latency", n, exp_lat);
    check("result", rd_v, exp);
    check("rdy_low_done", rdy_v, 1'b0);
    if (hold > 0) begin
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (rd_v !== exp || rv_v !== 1'b1 || rdy_v !== 1'b0 || ci_v !== 64'd0) ok = 1'b0;
      end
      check("bp_hold", ok, 1'b1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("post_hs", {rdy_v, rv_v, busy_v}, 3'b100);
    check("acc_once", acc_cnt - a0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] blk, got;
    int a1, a2;
    sel = 1'b0; blk_valid = 1'b0; res_ready = 1'b0; blk_data = '0; core_add = 1'b0;
    reset_n = 1'b0;
    #12;
    check("rst_blk_ready", blk_ready1, 1'b1);
    check("rst_res_valid", res_valid1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_core_in", core_in1, 64'd0);
    check("rst_res_data", res_data1, 512'd0);
    reset_n = 1'b1;
    tick();

    // Identity core, pixel i = i: output must equal input.
    for (int i = 0; i < 64; i++) blk[i*8 +: 8] = i[7:0];
    run_blk(blk, 0, 0, got);
    check("identity", got, blk);

    // +1 core, all 0xFF except pixel 9.
    core_add = 1'b1;
    blk = {512{1'b1}};
    blk[9*8 +: 8] = 8'h10;
    run_blk(blk, 0, 0, got);
    check("add_coef9", got[9*8 +: 8], 8'h12);
    check("add_coef0", got[7:0], 8'h01);

    // Backpressure for 10 cycles.
    core_add = 1'($urandom_range(0, 1));
    run_blk(rand_blk(), 10, 0, got);

    // blk_valid held high across two blocks.
    core_add = 1'b0;
    run_blk(rand_blk(), 0, 1, got);
    a1 = acc_cyc;
    run_blk(rand_blk(), 0, 1, got);
    blk_valid = 1'b0;
    a2 = acc_cyc;
    check("b2b_gap", a2 - a1, 20);

    // Reset pulsed during the column pass (cycle T+12).
    blk_data = rand_blk();
    blk_valid = 1'b1;
    while (!blk_ready1) tick();
    tick();
    blk_valid = 1'b0;
    repeat (11) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_res_valid", res_valid1, 1'b0);
    check("mid_rst_busy", busy1, 1'b0);
    check("mid_rst_core_in", core_in1, 64'd0);
    check("mid_rst_blk_ready", blk_ready1, 1'b1);
    #1;
    reset_n = 1'b1;
    tick();
    run_blk(rand_blk(), 0, 0, got);

    // Random blocks with random core function and hold times.
    for (int j = 0; j < 4; j++) begin
      core_add = 1'($urandom_range(0, 1));
      run_blk(rand_blk(), $urandom_range(0, 3), 0, got);
    end

    // Latency-3 instance, identity core, two blocks.
    sel = 1'b1;
    core_add = 1'b0;
    for (int i = 0; i < 64; i++) blk[i*8 +: 8] = i[7:0];
    run_blk(blk, 0, 0, got);
    check("identity_lat3", got, blk);
    run_blk(rand_blk(), 2, 0, got);
`ifdef DCT_SEQ_STATS_EN
    check("blk_count", blk_count3, 16'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
